// File: rtl/traffic_countdown_display.sv
// Two-digit countdown display for the traffic-light controller: sequential binary-to-BCD
// conversion, multiplexed digit scan with leading-zero blanking, and blinking in amber phases.
module traffic_countdown_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] time_left,
    input  logic [1:0] state,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic       busy
);

    localparam int unsigned ScanW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

    conv_state_e conv_q, conv_d;
    logic [4:0]  held_q, held_d;
    logic        pend_q, pend_d;
    logic [4:0]  bin_q, bin_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [2:0]  shift_cnt_q, shift_cnt_d;
    logic        busy_q, busy_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic              digit_sel_q, digit_sel_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [7:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;

    logic [7:0] bcd_adj;
    logic [3:0] digit_nib;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        unique case (nib)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Conversion FSM: capture, five add-3/shift steps, then publish the digits.
    always_comb begin
        conv_d      = conv_q;
        held_d      = held_q;
        pend_d      = pend_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        busy_d      = busy_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        bcd_adj     = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        unique case (conv_q)
            StIdle: begin
                if ((time_left != held_q) || pend_q) begin
                    held_d      = time_left;
                    pend_d      = 1'b0;
                    bin_d       = time_left;
                    bcd_d       = 8'd0;
                    shift_cnt_d = 3'd0;
                    busy_d      = 1'b1;
                    conv_d      = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj[6:0], bin_q, 1'b0};
                shift_cnt_d    = shift_cnt_q + 3'd1;
                if (shift_cnt_q == 3'd4) begin
                    conv_d = StDone;
                end
            end
            StDone: begin
                tens_d = bcd_q[7:4];
                ones_d = bcd_q[3:0];
                busy_d = 1'b0;
                conv_d = StIdle;
            end
            default: conv_d = StIdle;
        endcase
    end

    // Scan, blink and registered display outputs.
    always_comb begin
        scan_cnt_d    = scan_cnt_q + ScanW'(1);
        digit_sel_d   = digit_sel_q;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_d  = '0;
            digit_sel_d = ~digit_sel_q;
        end
        if (state[0]) begin
            blink_phase_d = blink_phase_q;
            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
        digit_nib = digit_sel_q ? tens_q : ones_q;
        seg_d     = seg_code(digit_nib);
        if (blink_phase_q) begin
            an_d = 2'b11;
        end else if (digit_sel_q) begin
            an_d = (tens_q == 4'd0) ? 2'b11 : 2'b01;
        end else begin
            an_d = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_q        <= StIdle;
            held_q        <= 5'd0;
            pend_q        <= 1'b1;
            bin_q         <= 5'd0;
            bcd_q         <= 8'd0;
            shift_cnt_q   <= 3'd0;
            busy_q        <= 1'b0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            scan_cnt_q    <= '0;
            digit_sel_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= 8'hFF;
            an_q          <= 2'b11;
        end else begin
            conv_q        <= conv_d;
            held_q        <= held_d;
            pend_q        <= pend_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            shift_cnt_q   <= shift_cnt_d;
            busy_q        <= busy_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_sel_q   <= digit_sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Bench for traffic_countdown_display: table of values with expected segment codes, a display
// scoreboard queue, and hand-written sequences for reset, blink and change-while-busy cases.
module tb_traffic_countdown_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] time_left;
    logic [1:0] state;
    logic [7:0] seg;
    logic [1:0] an;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [4:0] tl;
        logic [7:0] ones_seg;
        logic [7:0] tens_seg;
        logic       tens_blank;
    } vec_t;

    typedef struct packed {
        logic [7:0] ones_seg;
        logic [7:0] tens_seg;
        logic       tens_blank;
    } disp_t;

    disp_t sb_q[$];
    vec_t  vecs[8];

    traffic_countdown_display #(
        .SCAN_DIV (4),
        .BLINK_DIV(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .time_left(time_left),
        .state    (state),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Waits for a conversion to start, then counts its busy cycles; ends on the busy-low sample.
    task automatic conv_window(output int high);
        int waited = 0;
        high = 0;
        while (busy !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        while (busy === 1'b1 && high < 12) begin
            high++;
            tick();
        end
    endtask

    // Pops the expected display and watches one full scan period of 8 samples.
    task automatic check_display(input string tag);
        disp_t      e;
        int         n_ones = 0, n_tens = 0, n_blank = 0;
        logic [7:0] ones_seen = 8'h00, tens_seen = 8'h00;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (an == 2'b10) begin
                if (n_ones == 0 || seg != e.ones_seg) ones_seen = seg;
                n_ones++;
            end else if (an == 2'b01) begin
                if (n_tens == 0 || seg != e.tens_seg) tens_seen = seg;
                n_tens++;
            end else if (an == 2'b11) begin
                n_blank++;
            end
        end
        check({tag, " ones_slots"}, n_ones, 4);
        check({tag, " ones_seg"}, ones_seen, e.ones_seg);
        if (e.tens_blank) begin
            check({tag, " tens_blank_slots"}, n_blank, 4);
        end else begin
            check({tag, " tens_slots"}, n_tens, 4);
            check({tag, " tens_seg"}, tens_seen, e.tens_seg);
        end
    endtask

    task automatic apply_value(input vec_t v);
        int h;
        string tag;
        tag = $sformatf("tl%0d", v.tl);
        time_left = v.tl;
        sb_q.push_back('{ones_seg: v.ones_seg, tens_seg: v.tens_seg, tens_blank: v.tens_blank});
        conv_window(h);
        check({tag, " busy_len"}, h, 6);
        check_display(tag);
    endtask

    initial begin
        int         h;
        int         first_chg, second_chg, cnt, bad;
        logic [1:0] an_hist[16];
        logic [12:0] busy_vec;
        int         n27_ones, n27_tens;
        logic [7:0] s27_ones, s27_tens;

        vecs[0] = '{tl: 5'd7,  ones_seg: 8'hF8, tens_seg: 8'hFF, tens_blank: 1'b1};
        vecs[1] = '{tl: 5'd0,  ones_seg: 8'hC0, tens_seg: 8'hFF, tens_blank: 1'b1};
        vecs[2] = '{tl: 5'd31, ones_seg: 8'hF9, tens_seg: 8'hB0, tens_blank: 1'b0};
        vecs[3] = '{tl: 5'd10, ones_seg: 8'hC0, tens_seg: 8'hF9, tens_blank: 1'b0};
        vecs[4] = '{tl: 5'd29, ones_seg: 8'h90, tens_seg: 8'hA4, tens_blank: 1'b0};
        vecs[5] = '{tl: 5'd25, ones_seg: 8'h92, tens_seg: 8'hA4, tens_blank: 1'b0};
        vecs[6] = '{tl: 5'd14, ones_seg: 8'h99, tens_seg: 8'hF9, tens_blank: 1'b0};
        vecs[7] = '{tl: 5'd3,  ones_seg: 8'hB0, tens_seg: 8'hFF, tens_blank: 1'b1};

        rst_n     = 1'b0;
        time_left = 5'd18;
        state     = 2'b00;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset%0d seg", i), seg, 8'hFF);
            check($sformatf("reset%0d an", i), an, 2'b11);
            check($sformatf("reset%0d busy", i), busy, 1'b0);
        end

        rst_n = 1'b1;
        sb_q.push_back('{ones_seg: 8'h80, tens_seg: 8'hF9, tens_blank: 1'b0});
        conv_window(h);
        check("init busy_len", h, 6);
        check_display("init18");

        // Dwell: distance between two consecutive digit switches.
        for (int i = 0; i < 16; i++) begin
            tick();
            an_hist[i] = an;
        end
        first_chg  = 0;
        second_chg = 0;
        for (int i = 1; i < 16; i++) begin
            if (an_hist[i] != an_hist[i-1]) begin
                if (first_chg == 0) first_chg = i;
                else if (second_chg == 0) second_chg = i;
            end
        end
        check("scan dwell", second_chg - first_chg, 4);

        foreach (vecs[i]) apply_value(vecs[i]);

        // Amber blink with value 2 (tens blanked).
        apply_value('{tl: 5'd2, ones_seg: 8'hA4, tens_seg: 8'hFF, tens_blank: 1'b1});
        state = 2'b01;
        for (int w = 0; w < 5; w++) begin
            cnt = 0;
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (an == 2'b10) begin
                    cnt++;
                    if (seg != 8'hA4) bad++;
                end
            end
            check($sformatf("blink win%0d ones_slots", w), cnt, (w % 2 == 0) ? 4 : 0);
            check($sformatf("blink win%0d seg_bad", w), bad, 0);
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (an != 2'b11) cnt++;
        end
        check("blink dark_phase lit", cnt, 0);
        state = 2'b10;
        tick();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (an == 2'b10 && seg == 8'hA4) cnt++;
        end
        check("steady after amber", cnt, 4);

        // Change while busy: 28 -> 27 -> 26.
        apply_value('{tl: 5'd28, ones_seg: 8'h80, tens_seg: 8'hA4, tens_blank: 1'b0});
        time_left = 5'd27;
        tick();
        check("chg busy_start", busy, 1'b1);
        tick();
        time_left = 5'd26;
        n27_ones = 0;
        n27_tens = 0;
        s27_ones = 8'h00;
        s27_tens = 8'h00;
        for (int i = 0; i < 13; i++) begin
            tick();
            busy_vec[i] = busy;
            if (i >= 5 && i <= 11) begin
                if (an == 2'b10 && (n27_ones == 0 || seg != 8'hF8)) s27_ones = seg;
                if (an == 2'b01 && (n27_tens == 0 || seg != 8'hA4)) s27_tens = seg;
                if (an == 2'b10) n27_ones++;
                if (an == 2'b01) n27_tens++;
            end
        end
        check("chg busy_pattern", busy_vec, 13'b0011111101111);
        check("chg 27 ones_seg", s27_ones, 8'hF8);
        check("chg 27 tens_seg", s27_tens, 8'hA4);
        sb_q.push_back('{ones_seg: 8'h82, tens_seg: 8'hA4, tens_blank: 1'b0});
        check_display("chg26");

        // Reset landing on the third shift edge.
        time_left = 5'd13;
        tick();
        check("mid busy_start", busy, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid reset busy", busy, 1'b0);
        check("mid reset seg", seg, 8'hFF);
        check("mid reset an", an, 2'b11);
        rst_n = 1'b1;
        sb_q.push_back('{ones_seg: 8'hB0, tens_seg: 8'hF9, tens_blank: 1'b0});
        conv_window(h);
        check("mid fresh busy_len", h, 6);
        check_display("mid13");

        check("scoreboard drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
